timer_compare_datapath: RTL and testbench

Datapath that pairs with the timer-compare PLA controller. It executes that controller's control word (`La`, `Lb`, `Ea`, `Lr`, `Er`, `Kc`, `Cc`, `M`, `s`) and returns its status inputs (`Ts`, `c7`, `Az`). It snapshots the current BCD time and alarm target, and compares them one nibble per cycle. On a full match it drives a timed alarm output toward the display/buzzer logic of the digital clock.

---
 rtl/timer_compare_datapath.sv | 208 ++++++++++++++++++++
 tb/tb_timer_compare_datapath.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/timer_compare_datapath.sv
// Timer-compare datapath: executes the PLA controller's control word, compares time vs alarm nibble-serially
// and drives a timed alarm. Optional snooze support is compiled in with `define TC_SNOOZE_EN.
module timer_compare_datapath #(
    parameter int          DIGITS        = 8,
    parameter logic [31:0] RING_CYCLES   = 32'd50_000_000,
    parameter logic [31:0] SNOOZE_CYCLES = 32'd300_000_000,
    localparam int         CW            = $clog2(DIGITS)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [4*DIGITS-1:0] time_in,
    input  logic [4*DIGITS-1:0] alarm_in,
    input  logic                arm_btn,
    input  logic                snooze,
    input  logic                La,
    input  logic                Lb,
    input  logic                Ea,
    input  logic                Lr,
    input  logic                Er,
    input  logic                Kc,
    input  logic                Cc,
    input  logic                M,
    input  logic [1:0]          s,
    output logic                Ts,
    output logic                c7,
    output logic                Az,
    output logic                alarm_out,
    output logic [CW-1:0]       digit_idx
);

`ifdef TC_SNOOZE_EN
    typedef enum logic [1:0] {ST_IDLE, ST_RING, ST_SNOOZE} ring_state_t;
`else
    typedef enum logic [1:0] {ST_IDLE, ST_RING} ring_state_t;
`endif

    localparam logic [CW-1:0] LAST_DIGIT = CW'(DIGITS - 1);

    logic [DIGITS-1:0][3:0] r_a;
    logic [DIGITS-1:0][3:0] r_b;
    logic [DIGITS-1:0]      r_r;
    logic [CW-1:0]          r_cnt;

    logic [3:0] w_a_nib;
    logic [3:0] w_b_nib;
    logic       w_mismatch;

    logic r_arm_meta;
    logic r_arm_sync;
    logic r_arm_prev;
    logic r_ts;
    logic w_arm_rise;
    logic w_disarm;

    ring_state_t r_state;
    ring_state_t w_state_nxt;
    logic [31:0] r_ring_cnt;
    logic [31:0] w_ring_nxt;

`ifdef TC_SNOOZE_EN
    logic        r_snooze_prev;
    logic        w_snooze_rise;
    logic [31:0] r_snz_cnt;
    logic [31:0] w_snz_nxt;
`else
    logic        w_unused_snooze;
    assign w_unused_snooze = snooze ^ (|SNOOZE_CYCLES);
`endif

    // ---------------- compare datapath ----------------
    assign w_a_nib = r_a[r_cnt];
    assign w_b_nib = r_b[r_cnt];

    // NOTE: every output of an always_comb gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        w_mismatch = 1'b0;
        case (s)
            2'b00:   w_mismatch = (w_a_nib != w_b_nib);
            2'b01:   w_mismatch = (w_a_nib != 4'h0);
            default: w_mismatch = (w_b_nib != 4'hF) && (w_a_nib != w_b_nib);
        endcase
    end

    // NOTE: A/B are plain registers, not a RAM, so they take part in the reset like every other flop.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_a   <= '0;
            r_b   <= '0;
            r_r   <= '0;
            r_cnt <= '0;
        end else begin
            if (La) r_a <= time_in;
            if (Lb) r_b <= alarm_in;

            if (Lr)      r_r <= '0;
            else if (Er) r_r[r_cnt] <= r_r[r_cnt] | w_mismatch;

            if (Kc)      r_cnt <= '0;
            else if (Cc) r_cnt <= (r_cnt == LAST_DIGIT) ? '0 : r_cnt + 1'b1;
        end
    end

    assign Az        = (r_r == '0);
    assign c7        = (r_cnt == LAST_DIGIT);
    assign digit_idx = r_cnt;

    // ---------------- arm synchronizer and toggle ----------------
    assign w_arm_rise = r_arm_sync & ~r_arm_prev;
    assign w_disarm   = w_arm_rise & r_ts;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_arm_meta <= 1'b0;
            r_arm_sync <= 1'b0;
            r_arm_prev <= 1'b0;
            r_ts       <= 1'b0;
        end else begin
            r_arm_meta <= arm_btn;
            r_arm_sync <= r_arm_meta;
            r_arm_prev <= r_arm_sync;
            r_ts       <= r_ts ^ w_arm_rise;
        end
    end

    assign Ts = r_ts;

`ifdef TC_SNOOZE_EN
    assign w_snooze_rise = snooze & ~r_snooze_prev;

    always_ff @(posedge clk) begin
        if (rst) r_snooze_prev <= 1'b0;
        else     r_snooze_prev <= snooze;
    end
`endif

    // ---------------- ring state machine ----------------
    // Priority inside RING: disarm/Ea, then snooze, then M retrigger, then countdown.
    always_comb begin
        w_state_nxt = r_state;
        w_ring_nxt  = r_ring_cnt;
`ifdef TC_SNOOZE_EN
        w_snz_nxt   = r_snz_cnt;
`endif
        case (r_state)
            ST_IDLE: begin
                if (M && Az && r_ts && !Ea && !w_disarm) begin
                    w_state_nxt = ST_RING;
                    w_ring_nxt  = RING_CYCLES - 32'd1;
                end
            end
            ST_RING: begin
                if (w_disarm || Ea) begin
                    w_state_nxt = ST_IDLE;
                    w_ring_nxt  = '0;
`ifdef TC_SNOOZE_EN
                end else if (w_snooze_rise) begin
                    w_state_nxt = ST_SNOOZE;
                    w_ring_nxt  = '0;
                    w_snz_nxt   = SNOOZE_CYCLES - 32'd1;
`endif
                end else if (M) begin
                    w_ring_nxt  = RING_CYCLES - 32'd1;
                end else if (r_ring_cnt == '0) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_ring_nxt  = r_ring_cnt - 32'd1;
                end
            end
`ifdef TC_SNOOZE_EN
            ST_SNOOZE: begin
                if (w_disarm || Ea) begin
                    w_state_nxt = ST_IDLE;
                    w_snz_nxt   = '0;
                end else if (r_snz_cnt == '0) begin
                    w_state_nxt = ST_RING;
                    w_ring_nxt  = RING_CYCLES - 32'd1;
                end else begin
                    w_snz_nxt   = r_snz_cnt - 32'd1;
                end
            end
`endif
            default: begin
                w_state_nxt = ST_IDLE;
                w_ring_nxt  = '0;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_ring_cnt <= '0;
`ifdef TC_SNOOZE_EN
            r_snz_cnt  <= '0;
`endif
        end else begin
            r_state    <= w_state_nxt;
            r_ring_cnt <= w_ring_nxt;
`ifdef TC_SNOOZE_EN
            r_snz_cnt  <= w_snz_nxt;
`endif
        end
    end

    assign alarm_out = (r_state == ST_RING);

endmodule

// File: tb/tb_timer_compare_datapath.sv
// Scoreboard bench for timer_compare_datapath: the driver pushes per-cycle expectations from a
// behavioural model; a monitor pops and compares them one time unit after each rising edge.
module tb_timer_compare_datapath;
    localparam int DIGITS = 8;
    localparam int CW     = 3;
    localparam int RC     = 10;
    localparam int SC     = 6;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [31:0] time_in, alarm_in;
    logic        arm_btn, snooze, La, Lb, Ea, Lr, Er, Kc, Cc, M;
    logic [1:0]  s;
    logic        Ts, c7, Az, alarm_out;
    logic [CW-1:0] digit_idx;

    timer_compare_datapath #(
        .DIGITS(DIGITS), .RING_CYCLES(32'(RC)), .SNOOZE_CYCLES(32'(SC))
    ) dut (
        .clk(clk), .rst(rst), .time_in(time_in), .alarm_in(alarm_in),
        .arm_btn(arm_btn), .snooze(snooze), .La(La), .Lb(Lb), .Ea(Ea), .Lr(Lr),
        .Er(Er), .Kc(Kc), .Cc(Cc), .M(M), .s(s),
        .Ts(Ts), .c7(c7), .Az(Az), .alarm_out(alarm_out), .digit_idx(digit_idx)
    );

    typedef struct {
        string tag;
        bit    az;
        bit    c7;
        bit    ts;
        bit    al;
        int    idx;
    } exp_t;

    exp_t  sb[$];
    int    n_checks = 0;
    int    n_pass   = 0;
    string cur_tag  = "init";

    // Reference model: nibble arrays, a mismatch-bit array, a digit index and
    // "cycles remaining" counts for ringing/snoozing.
    logic [3:0] m_a [DIGITS];
    logic [3:0] m_b [DIGITS];
    bit         m_r [DIGITS];
    int         m_cnt = 0;
    bit         m_ts = 0;
    bit         m_arm_h [3];      // arm_btn as sampled 1, 2 and 3 edges ago
    int         m_ring_left = 0;  // cycles of alarm_out still to come, 0 = not ringing
    int         m_snz_left = 0;   // quiet cycles still to come, 0 = not snoozing
    bit         m_snz_prev = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    function automatic bit model_az();
        for (int i = 0; i < DIGITS; i++) if (m_r[i]) return 1'b0;
        return 1'b1;
    endfunction

    task automatic model_step();
        exp_t       e;
        bit         az_old, mm, rise, disarm, snz_rise;
        logic [3:0] a, b;
        if (rst) begin
            for (int i = 0; i < DIGITS; i++) begin
                m_a[i] = 4'h0; m_b[i] = 4'h0; m_r[i] = 1'b0;
            end
            m_cnt = 0; m_ts = 0;
            for (int i = 0; i < 3; i++) m_arm_h[i] = 1'b0;
            m_ring_left = 0; m_snz_left = 0; m_snz_prev = 0;
        end else begin
            az_old = model_az();
            a = m_a[m_cnt];
            b = m_b[m_cnt];
            case (s)
                2'd0:    mm = (a != b);
                2'd1:    mm = (a != 4'h0);
                default: mm = (b != 4'hF) && (a != b);
            endcase
            rise     = m_arm_h[1] && !m_arm_h[2];
            disarm   = rise && m_ts;
            snz_rise = 1'b0;
`ifdef TC_SNOOZE_EN
            snz_rise = snooze && !m_snz_prev;
`endif
            if (m_ring_left > 0) begin
                if (disarm || Ea) m_ring_left = 0;
                else if (snz_rise) begin
                    m_ring_left = 0;
                    m_snz_left  = SC;
                end else if (M) m_ring_left = RC;
                else m_ring_left--;
            end else if (m_snz_left > 0) begin
                if (disarm || Ea) m_snz_left = 0;
                else if (m_snz_left == 1) begin
                    m_snz_left  = 0;
                    m_ring_left = RC;
                end else m_snz_left--;
            end else if (M && !Ea && !disarm && az_old && m_ts) begin
                m_ring_left = RC;
            end

            if (Lr) for (int i = 0; i < DIGITS; i++) m_r[i] = 1'b0;
            else if (Er && mm) m_r[m_cnt] = 1'b1;
            for (int i = 0; i < DIGITS; i++) begin
                if (La) m_a[i] = time_in[4*i +: 4];
                if (Lb) m_b[i] = alarm_in[4*i +: 4];
            end
            if (Kc) m_cnt = 0;
            else if (Cc) m_cnt = (m_cnt + 1) % DIGITS;
            if (rise) m_ts = !m_ts;
            m_arm_h[2] = m_arm_h[1];
            m_arm_h[1] = m_arm_h[0];
            m_arm_h[0] = arm_btn;
            m_snz_prev = snooze;
        end
        e.tag = cur_tag;
        e.az  = model_az();
        e.c7  = (m_cnt == DIGITS - 1);
        e.ts  = m_ts;
        e.al  = (m_ring_left > 0);
        e.idx = m_cnt;
        sb.push_back(e);
    endtask

    // Inputs are set at the falling edge; the expectation for the next rising edge is queued.
    task automatic tick();
        model_step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic clear_ctl();
        La = 0; Lb = 0; Ea = 0; Lr = 0; Er = 0; Kc = 0; Cc = 0; M = 0; s = 2'd0;
    endtask

    task automatic compare_run(input logic [31:0] t, input logic [31:0] al, input logic [1:0] sel);
        time_in = t; alarm_in = al;
        La = 1; Lb = 1; tick(); clear_ctl();
        Lr = 1; Kc = 1; tick(); clear_ctl();
        for (int i = 0; i < DIGITS; i++) begin
            Er = 1; Cc = 1; s = sel; tick();
        end
        clear_ctl();
    endtask

    task automatic arm_pulse();
        arm_btn = 1; repeat (4) tick();
        arm_btn = 0; repeat (4) tick();
    endtask

    task automatic fire();
        M = 1; tick(); M = 0;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check({e.tag, ".Az"},        32'(Az),        32'(e.az));
                check({e.tag, ".c7"},        32'(c7),        32'(e.c7));
                check({e.tag, ".Ts"},        32'(Ts),        32'(e.ts));
                check({e.tag, ".alarm_out"}, 32'(alarm_out), 32'(e.al));
                check({e.tag, ".digit_idx"}, 32'(digit_idx), 32'(e.idx));
            end
        end
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: bench did not finish, got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin : driver
        rst = 1; arm_btn = 0; snooze = 0; time_in = '0; alarm_in = '0;
        clear_ctl();

        cur_tag = "reset";    repeat (2) tick();
        rst = 0;
        cur_tag = "arm";      arm_pulse();

        cur_tag = "exact";    compare_run(32'h0112_3045, 32'h0112_3045, 2'd0);
        cur_tag = "exact_m";  fire();
        cur_tag = "ring10";   repeat (12) tick();

        cur_tag = "mismatch"; compare_run(32'h0112_3045, 32'h0112_3046, 2'd0);
        cur_tag = "mism_m";   fire(); repeat (3) tick();

        cur_tag = "zero_tst"; compare_run(32'h0000_0000, 32'h0112_3046, 2'd1);
        cur_tag = "wildcard"; compare_run(32'h0112_3045, 32'h0112_304F, 2'd2);
        cur_tag = "wild_m";   fire(); repeat (3) tick();
        cur_tag = "ea_and_m"; Ea = 1; M = 1; tick(); clear_ctl(); repeat (2) tick();

        cur_tag = "retrig";   fire(); repeat (4) tick();
        M = 1; tick(); M = 0;
        repeat (16) tick();

        cur_tag = "disarm";   fire(); repeat (3) tick(); arm_pulse();
        cur_tag = "unarmed";  fire(); repeat (3) tick();

`ifdef TC_SNOOZE_EN
        cur_tag = "snooze";   arm_pulse(); fire(); repeat (3) tick();
        snooze = 1; tick(); snooze = 0;
        repeat (20) tick();
`endif

        cur_tag = "random";
        for (int n = 0; n < 500; n++) begin
            logic [31:0] t, al;
            t = $urandom();
            for (int i = 0; i < DIGITS; i++) begin
                case ($urandom_range(0, 9))
                    0, 1:    al[4*i +: 4] = 4'hF;
                    2, 3:    al[4*i +: 4] = 4'($urandom());
                    default: al[4*i +: 4] = t[4*i +: 4];
                endcase
            end
            if ($urandom_range(0, 3) == 0) time_in  = t;
            if ($urandom_range(0, 3) == 0) alarm_in = al;
            rst = ($urandom_range(0, 99) == 0);
            La  = ($urandom_range(0, 4) == 0);
            Lb  = ($urandom_range(0, 4) == 0);
            Lr  = ($urandom_range(0, 5) == 0);
            Er  = ($urandom_range(0, 1) == 0);
            Kc  = ($urandom_range(0, 7) == 0);
            Cc  = ($urandom_range(0, 1) == 0);
            M   = ($urandom_range(0, 4) == 0);
            Ea  = ($urandom_range(0, 19) == 0);
            s   = 2'($urandom());
            if ($urandom_range(0, 29) == 0) arm_btn = ~arm_btn;
            if ($urandom_range(0, 14) == 0) snooze  = ~snooze;
            tick();
        end
        rst = 0; clear_ctl();
        tick();

        check("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
